// File: rtl/phi_pkg.sv
// Shared constants for the phi_t issue/collect path.
package phi_pkg;

  localparam int PHI_DATA_W = 64;
  localparam int PHI_DEPTH  = 16;

  localparam logic [63:0] NEG_ONE = 64'hBFF0000000000000;
  localparam logic [63:0] ONE     = 64'h3FF0000000000000;

  // Counter width able to hold the values 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/phi_t_collector_if.sv
// Request/issue and result-stream signals between upstream, phi_t and downstream.
interface phi_t_collector_if #(
  parameter int DATA_W = phi_pkg::PHI_DATA_W
);

  logic              req_vld;
  logic              req_rdy;
  logic              start;
  logic [DATA_W-1:0] phi_t;
  logic              phi_t_vld;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tready;

  // Environment side: requester, phi_t result source and downstream sink.
  modport master (
    output req_vld, phi_t, phi_t_vld, m_tready,
    input  req_rdy, start, m_tdata, m_tvalid
  );

  // Collector side.
  modport slave (
    input  req_vld, phi_t, phi_t_vld, m_tready,
    output req_rdy, start, m_tdata, m_tvalid
  );

endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; head is visible without a read strobe.
module sync_fifo_fwft import phi_pkg::*; #(
  parameter int DATA_W = PHI_DATA_W,
  parameter int DEPTH  = PHI_DEPTH,
  parameter int CNT_W  = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic [CNT_W-1:0]  level,
  output logic              full,
  output logic              empty
);

  localparam int              PTR_W   = CNT_W - 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (level == '0);
  assign full    = (level == DEPTH_C);
  // Pops on an empty FIFO are ignored; a push when full only lands if a pop frees the slot.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head comes straight from storage, so a write is never bypassed to the output.
  assign dout    = mem[rd_ptr];

  // Storage array; data is not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + CNT_W'(1);
        2'b01:   level <= level - CNT_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/phi_t_collector.sv
// Credit-gated issue of phi_t operations and in-order collection of their results.
module phi_t_collector import phi_pkg::*; #(
  parameter int DATA_W = PHI_DATA_W,
  parameter int DEPTH  = PHI_DEPTH,
  parameter int CNT_W  = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  phi_t_collector_if.slave bus,
  output logic [CNT_W-1:0] level,
  output logic [CNT_W-1:0] inflight,
  output logic             overflow,
  output logic             spurious
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [CNT_W-1:0]  credits;
  logic              accept;
  logic              pop;
  logic              full;
  logic              empty;
  logic              start_q;
  logic [DATA_W-1:0] fifo_dout;

  // Every outstanding operation owns a reserved FIFO slot, so results can never be dropped.
  assign credits      = DEPTH_C - level - inflight;
  assign bus.req_rdy  = (credits != '0);
  assign accept       = bus.req_vld && bus.req_rdy;
  assign pop          = bus.m_tvalid && bus.m_tready;
  assign bus.start    = start_q;
  assign bus.m_tdata  = fifo_dout;
  assign bus.m_tvalid = !empty;

  sync_fifo_fwft #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bus.phi_t_vld),
    .din   (bus.phi_t),
    .pop   (bus.m_tready),
    .dout  (fifo_dout),
    .level (level),
    .full  (full),
    .empty (empty)
  );

  // One start pulse per accepted request, one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) start_q <= 1'b0;
    else        start_q <= accept;
  end

  // Outstanding-operation count; a result with nothing outstanding leaves it at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else if (accept && !bus.phi_t_vld) begin
      inflight <= inflight + CNT_W'(1);
    end else if (!accept && bus.phi_t_vld && (inflight != '0)) begin
      inflight <= inflight - CNT_W'(1);
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      spurious <= 1'b0;
    end else begin
      if (bus.phi_t_vld && full && !pop) overflow <= 1'b1;
      if (bus.phi_t_vld && (inflight == '0)) spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_phi_t_collector.sv
// Directed and randomized bench for phi_t_collector against a queue-based model.
module tb_phi_t_collector;
  import phi_pkg::*;

  localparam int DEPTH = 16;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [CNT_W-1:0] level;
  logic [CNT_W-1:0] inflight;
  logic             overflow;
  logic             spurious;

  phi_t_collector_if #(.DATA_W(64)) bus ();

  phi_t_collector #(.DATA_W(64), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .level    (level),
    .inflight (inflight),
    .overflow (overflow),
    .spurious (spurious)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: the results held in the FIFO, in order, plus counters and flags.
  logic [63:0] q[$];
  int          infl_m;
  bit          ovf_m;
  bit          spur_m;
  bit          start_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    infl_m  = 0;
    ovf_m   = 1'b0;
    spur_m  = 1'b0;
    start_m = 1'b0;
  endtask

  function automatic int credits_m();
    return DEPTH - q.size() - infl_m;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, "_req_rdy"},  64'(bus.req_rdy),  64'(credits_m() != 0));
    chk({tag, "_start"},    64'(bus.start),    64'(start_m));
    chk({tag, "_level"},    64'(level),        64'(q.size()));
    chk({tag, "_inflight"}, 64'(inflight),     64'(infl_m));
    chk({tag, "_m_tvalid"}, 64'(bus.m_tvalid), 64'(q.size() != 0));
    chk({tag, "_overflow"}, 64'(overflow),     64'(ovf_m));
    chk({tag, "_spurious"}, 64'(spurious),     64'(spur_m));
    if (q.size() != 0) chk({tag, "_m_tdata"}, bus.m_tdata, q[0]);
  endtask

  // One clock: model evaluates the current inputs, then the DUT is compared after the edge.
  task automatic tick(input string tag);
    bit acc, popm, fullm;
    acc   = bus.req_vld && (credits_m() != 0);
    popm  = bus.m_tready && (q.size() != 0);
    fullm = (q.size() == DEPTH);
    if (bus.phi_t_vld) begin
      if (infl_m == 0) spur_m = 1'b1;
      if (fullm && !popm) ovf_m = 1'b1;
    end
    if (popm) void'(q.pop_front());
    if (bus.phi_t_vld && (!fullm || popm)) q.push_back(bus.phi_t);
    if (acc && !bus.phi_t_vld) infl_m++;
    else if (!acc && bus.phi_t_vld && infl_m > 0) infl_m--;
    start_m = acc;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    bus.req_vld   = 1'b0;
    bus.phi_t_vld = 1'b0;
    bus.phi_t     = '0;
    bus.m_tready  = 1'b0;
  endtask

  initial begin
    int startcnt;
    int issued;
    int pushed;
    int guard;

    idle_inputs();
    model_reset();
    #1 rst_n = 1'b0;
    #2 check_all("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check_all("release");

    // Single request, start one cycle after accept, then its result.
    bus.req_vld = 1'b1;
    tick("t1_acc");
    chk("t1_start_pulse", 64'(bus.start), 64'd1);
    chk("t1_inflight1", 64'(inflight), 64'd1);
    bus.req_vld = 1'b0;
    tick("t1_idle");
    chk("t1_start_drop", 64'(bus.start), 64'd0);
    bus.phi_t_vld = 1'b1;
    bus.phi_t     = 64'h4000000000000000;
    tick("t1_res");
    bus.phi_t_vld = 1'b0;
    chk("t1_tvalid", 64'(bus.m_tvalid), 64'd1);
    chk("t1_tdata", bus.m_tdata, 64'h4000000000000000);
    chk("t1_inflight0", 64'(inflight), 64'd0);
    chk("t1_level1", 64'(level), 64'd1);
    bus.m_tready = 1'b1;
    tick("t1_pop");
    tick("t1_pop_empty");
    bus.m_tready = 1'b0;

    // Result with nothing outstanding.
    bus.phi_t_vld = 1'b1;
    bus.phi_t     = ONE;
    tick("t5_spur");
    bus.phi_t_vld = 1'b0;
    chk("t5_spurious", 64'(spurious), 64'd1);
    chk("t5_inflight", 64'(inflight), 64'd0);
    tick("t5_sticky");

    bus.m_tready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #2 check_all("rst2");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Saturate credits with requests held high and no downstream pops.
    startcnt    = 0;
    bus.req_vld = 1'b1;
    for (int i = 0; i < 60; i++) begin
      bus.phi_t_vld = (infl_m > 0) && ($urandom_range(0, 2) == 0);
      bus.phi_t     = {$urandom, $urandom};
      tick("t2");
      if (bus.start) startcnt++;
    end
    bus.req_vld = 1'b0;
    chk("t2_accepts", 64'(startcnt), 64'd16);
    chk("t2_req_rdy0", 64'(bus.req_rdy), 64'd0);
    chk("t2_sum", 64'(level) + 64'(inflight), 64'd16);
    chk("t2_no_ovf", 64'(overflow), 64'd0);
    guard = 0;
    while (infl_m > 0 && guard < 40) begin
      bus.phi_t_vld = 1'b1;
      bus.phi_t     = {$urandom, $urandom};
      tick("t2_ret");
      guard++;
    end
    bus.phi_t_vld = 1'b0;
    chk("t2_full", 64'(level), 64'd16);

    // Full FIFO: push and pop together, then push alone.
    bus.phi_t_vld = 1'b1;
    bus.phi_t     = NEG_ONE;
    bus.m_tready  = 1'b1;
    tick("t3_pushpop");
    chk("t3_level16", 64'(level), 64'd16);
    chk("t3_no_ovf", 64'(overflow), 64'd0);
    bus.m_tready = 1'b0;
    bus.phi_t    = ONE;
    tick("t3_push_full");
    bus.phi_t_vld = 1'b0;
    chk("t3_ovf", 64'(overflow), 64'd1);
    tick("t3_ovf_sticky");
    chk("t3_ovf_held", 64'(overflow), 64'd1);

    // Random streaming of 40 further results across pointer wrap.
    issued = 0;
    pushed = 0;
    guard  = 0;
    while ((issued < 40 || infl_m > 0 || q.size() != 0) && guard < 3000) begin
      bus.req_vld   = (issued < 40) && ($urandom_range(0, 1) == 1);
      bus.phi_t_vld = (infl_m > 0) && ($urandom_range(0, 2) != 0);
      bus.phi_t     = {$urandom, $urandom};
      bus.m_tready  = ($urandom_range(0, 1) == 1);
      if (bus.req_vld && credits_m() != 0) issued++;
      if (bus.phi_t_vld) pushed++;
      tick("t4");
      guard++;
    end
    idle_inputs();
    chk("t4_done", 64'(guard < 3000), 64'd1);
    chk("t4_pushed", 64'(pushed), 64'd40);

    // Build level=5, inflight=3, then reset mid-operation.
    bus.req_vld = 1'b1;
    repeat (8) tick("t6_issue");
    bus.req_vld   = 1'b0;
    bus.phi_t_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.phi_t = 64'(i) + ONE;
      tick("t6_ret");
    end
    bus.phi_t_vld = 1'b0;
    chk("t6_level5", 64'(level), 64'd5);
    chk("t6_infl3", 64'(inflight), 64'd3);
    rst_n = 1'b0;
    #2;
    chk("t6_async_level", 64'(level), 64'd0);
    chk("t6_async_infl", 64'(inflight), 64'd0);
    chk("t6_async_tvalid", 64'(bus.m_tvalid), 64'd0);
    chk("t6_async_ovf", 64'(overflow), 64'd0);
    chk("t6_async_spur", 64'(spurious), 64'd0);
    chk("t6_async_start", 64'(bus.start), 64'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("t6_req_rdy", 64'(bus.req_rdy), 64'd1);
    tick("t6_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
